sc_register_bank: RTL

//  16-entry x DATAWIDTH_BUS register bank of the uDATAPATH, directly upstream of the
//  B/A-bus 16:1 read multiplexers. Owns state for r0..r15, written from the C bus
//  at the 6-bit MIR C-address, and exposes all 16 registers in parallel to the muxes.
//  r0 is hard-wired zero, r14 is the PC with auto-increment, and a write-ack pulse

---
 rtl/sc_register_bank_pkg.sv | 23 ++
 rtl/sc_register_cell.sv | 21 ++
 rtl/sc_register_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/sc_register_bank_pkg.sv
// Shared constants, types and helpers for the uDATAPATH register bank.
// Changing the bank geometry, the PC slot or its step is done here.
package sc_register_bank_pkg;

  localparam int DATAWIDTH_BUS           = 32;
  localparam int DATAWIDTH_MIR_DIRECTION = 6;
  localparam int REG_COUNT               = 16;
  localparam int ZERO_INDEX              = 0;
  localparam int PC_INDEX                = 14;  // must stay within 1..REG_COUNT-1
  localparam int PC_STEP                 = 4;

  localparam int FIRST_WRITABLE = ZERO_INDEX + 1;
  localparam int LAST_WRITABLE  = REG_COUNT - 1;

  typedef logic [DATAWIDTH_BUS-1:0]           word_t;
  typedef logic [DATAWIDTH_MIR_DIRECTION-1:0] caddr_t;

  // True for C-addresses that name a real, writable register (r1..r15).
  function automatic logic is_writable(input caddr_t addr);
    return (addr >= caddr_t'(FIRST_WRITABLE)) && (addr <= caddr_t'(LAST_WRITABLE));
  endfunction

endpackage

// File: rtl/sc_register_cell.sv
// One bank register: load-enable flop with asynchronous active-low clear.
module sc_register_cell
  import sc_register_bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sc_register_bank.sv
// 16 x DATAWIDTH_BUS register bank: r0 tied to zero, r1..r15 written from the C bus,
// r14 doubles as the auto-incrementing PC, and a one-cycle ack confirms each write.
module sc_register_bank
  import sc_register_bank_pkg::*;
(
  input  logic   SC_REGBANK_CLOCK_50,
  input  logic   SC_REGBANK_RESET_InLow,
  input  word_t  SC_REGBANK_C_InBus,
  input  caddr_t SC_REGBANK_CAddress_InBus,
  input  logic   SC_REGBANK_Write_In,
  input  logic   SC_REGBANK_PCInc_In,
  output word_t  SC_REGBANK_data0_OutBus,
  output word_t  SC_REGBANK_data1_OutBus,
  output word_t  SC_REGBANK_data2_OutBus,
  output word_t  SC_REGBANK_data3_OutBus,
  output word_t  SC_REGBANK_data4_OutBus,
  output word_t  SC_REGBANK_data5_OutBus,
  output word_t  SC_REGBANK_data6_OutBus,
  output word_t  SC_REGBANK_data7_OutBus,
  output word_t  SC_REGBANK_data8_OutBus,
  output word_t  SC_REGBANK_data9_OutBus,
  output word_t  SC_REGBANK_data10_OutBus,
  output word_t  SC_REGBANK_data11_OutBus,
  output word_t  SC_REGBANK_data12_OutBus,
  output word_t  SC_REGBANK_data13_OutBus,
  output word_t  SC_REGBANK_data14_OutBus,
  output word_t  SC_REGBANK_data15_OutBus,
  output logic   SC_REGBANK_WriteAck_Out
);

  logic clk;
  logic rst_n;
  assign clk   = SC_REGBANK_CLOCK_50;
  assign rst_n = SC_REGBANK_RESET_InLow;

  word_t                regs      [REG_COUNT-1:1];
  logic [REG_COUNT-1:1] write_sel;
  logic                 write_accepted;

  // Full 6-bit compare, so addresses 16..63 never alias onto r0..r15.
  assign write_accepted = SC_REGBANK_Write_In && is_writable(SC_REGBANK_CAddress_InBus);

  for (genvar i = FIRST_WRITABLE; i < REG_COUNT; i++) begin : g_cell
    assign write_sel[i] = SC_REGBANK_Write_In &&
                          (SC_REGBANK_CAddress_InBus == caddr_t'(i));

    if (i == PC_INDEX) begin : g_pc
      word_t pc_next;
      logic  pc_load;

      // An explicit write to the PC takes priority over the increment.
      assign pc_load = write_sel[i] | SC_REGBANK_PCInc_In;
      assign pc_next = write_sel[i] ? SC_REGBANK_C_InBus
                                    : regs[i] + word_t'(PC_STEP);

      sc_register_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_next),
        .q     (regs[i])
      );
    end else begin : g_gp
      sc_register_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (write_sel[i]),
        .d     (SC_REGBANK_C_InBus),
        .q     (regs[i])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SC_REGBANK_WriteAck_Out <= 1'b0;
    end else begin
      SC_REGBANK_WriteAck_Out <= write_accepted;
    end
  end

  assign SC_REGBANK_data0_OutBus  = '0;
  assign SC_REGBANK_data1_OutBus  = regs[1];
  assign SC_REGBANK_data2_OutBus  = regs[2];
  assign SC_REGBANK_data3_OutBus  = regs[3];
  assign SC_REGBANK_data4_OutBus  = regs[4];
  assign SC_REGBANK_data5_OutBus  = regs[5];
  assign SC_REGBANK_data6_OutBus  = regs[6];
  assign SC_REGBANK_data7_OutBus  = regs[7];
  assign SC_REGBANK_data8_OutBus  = regs[8];
  assign SC_REGBANK_data9_OutBus  = regs[9];
  assign SC_REGBANK_data10_OutBus = regs[10];
  assign SC_REGBANK_data11_OutBus = regs[11];
  assign SC_REGBANK_data12_OutBus = regs[12];
  assign SC_REGBANK_data13_OutBus = regs[13];
  assign SC_REGBANK_data14_OutBus = regs[14];
  assign SC_REGBANK_data15_OutBus = regs[15];

endmodule
